// File: rtl/round_sequencer_pkg.sv
// Shared encodings for the two-player quiz match controller: FSM states,
// verdict codes sent to the HP manager and result codes read back from it.
package round_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_Q,
      S_WAIT_Q,
      S_ANSWER,
      S_VERDICT,
      S_GAP,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [1:0] V_NONE = 2'b00;
   localparam logic [1:0] V_P1   = 2'b01;
   localparam logic [1:0] V_P2   = 2'b10;
   localparam logic [1:0] V_DRAW = 2'b11;

   localparam logic [1:0] R_RUN    = 2'b00;
   localparam logic [1:0] R_P2_WIN = 2'b01;
   localparam logic [1:0] R_P1_WIN = 2'b10;

   // The HP manager never legitimately reports both winners; treat that as running.
   function automatic logic [1:0] clean_result(input logic [1:0] r);
      case (r)
         R_P1_WIN, R_P2_WIN: return r;
         default:            return R_RUN;
      endcase
   endfunction

endpackage

// File: rtl/round_sequencer_timer.sv
// Answer-window down-counter: load, decrement while enabled, clear on round end.
module round_sequencer_timer #(
   parameter int TW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          load,
   input  logic          en,
   input  logic          clr,
   input  logic [TW-1:0] load_val,
   output logic [TW-1:0] count,
   output logic          expired
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - TW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/round_sequencer.sv
// Match-level controller for the factorization quiz: question request, answer
// window with lockouts and first-correct arbitration, verdict pulse, end-of-match check.
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int TW         = 16,
   parameter int TIME_LIMIT = 50000,
   parameter int GAP_CYCLES = 4,
   parameter int RW         = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          Q_READY,
   input  logic          P1_VALID,
   input  logic          P1_CORRECT,
   input  logic          P2_VALID,
   input  logic          P2_CORRECT,
   input  logic [1:0]    RESULT_IN,
   output logic          NEW_Q,
   output logic [1:0]    VERDICT,
   output logic [TW-1:0] TIMER_OUT,
   output logic [RW-1:0] ROUND_CNT,
   output logic          MATCH_OVER,
   output logic [1:0]    WINNER
);

   localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] LOAD_VAL = TW'(TIME_LIMIT);

   function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
      return (&v) ? v : v + RW'(1);
   endfunction

   state_t        state, state_nxt;
   logic          lock_p1, lock_p2;
   logic          p1_ok, p1_bad, p2_ok, p2_bad;
   logic [1:0]    arb;
   logic [1:0]    verdict_q;
   logic [GW-1:0] gap_cnt;
   logic [1:0]    result_clean;
   logic [TW-1:0] tmr_count;
   logic          tmr_expired;
   logic          tmr_load, tmr_en, tmr_clr;

   assign result_clean = clean_result(RESULT_IN);
   assign tmr_load     = (state == S_WAIT_Q) && Q_READY;
   assign tmr_en       = (state == S_ANSWER);
   assign tmr_clr      = (state == S_ANSWER) && (arb != V_NONE);

   round_sequencer_timer #(.TW(TW)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (tmr_load),
      .en       (tmr_en),
      .clr      (tmr_clr),
      .load_val (LOAD_VAL),
      .count    (tmr_count),
      .expired  (tmr_expired)
   );

   // A correct answer outranks a lockout draw, which outranks window expiry.
   always_comb begin
      p1_ok  = P1_VALID && !lock_p1 &&  P1_CORRECT;
      p1_bad = P1_VALID && !lock_p1 && !P1_CORRECT;
      p2_ok  = P2_VALID && !lock_p2 &&  P2_CORRECT;
      p2_bad = P2_VALID && !lock_p2 && !P2_CORRECT;
      arb    = V_NONE;
      if (p1_ok && p2_ok)                                     arb = V_DRAW;
      else if (p1_ok)                                         arb = V_P1;
      else if (p2_ok)                                         arb = V_P2;
      else if ((lock_p1 || p1_bad) && (lock_p2 || p2_bad))    arb = V_DRAW;
      else if (tmr_expired)                                   arb = V_DRAW;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (START)   state_nxt = S_REQ_Q;
         S_REQ_Q:                state_nxt = S_WAIT_Q;
         S_WAIT_Q:  if (Q_READY) state_nxt = S_ANSWER;
         S_ANSWER:  if (arb != V_NONE) state_nxt = S_VERDICT;
         S_VERDICT:              state_nxt = S_GAP;
         S_GAP:     if (gap_cnt == GAP_LAST) state_nxt = S_CHECK;
         S_CHECK:   state_nxt = (result_clean != R_RUN) ? S_DONE : S_REQ_Q;
         S_DONE:    if (START)   state_nxt = S_REQ_Q;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lock_p1   <= 1'b0;
         lock_p2   <= 1'b0;
         gap_cnt   <= '0;
         ROUND_CNT <= '0;
         WINNER    <= R_RUN;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (START) begin
               ROUND_CNT <= '0;
               WINNER    <= R_RUN;
            end
            S_WAIT_Q: if (Q_READY) begin
               lock_p1 <= 1'b0;
               lock_p2 <= 1'b0;
            end
            S_ANSWER: begin
               lock_p1 <= lock_p1 || p1_bad;
               lock_p2 <= lock_p2 || p2_bad;
            end
            S_VERDICT: begin
               ROUND_CNT <= sat_inc(ROUND_CNT);
               gap_cnt   <= '0;
            end
            S_GAP:   gap_cnt <= gap_cnt + GW'(1);
            S_CHECK: if (result_clean != R_RUN) WINNER <= result_clean;
            default: ;
         endcase
      end
   end

   // Decided code is only ever observed in S_VERDICT, after it has been written.
   always_ff @(posedge CLK) begin
      if ((state == S_ANSWER) && (arb != V_NONE)) verdict_q <= arb;
   end

   assign NEW_Q      = (state == S_REQ_Q);
   assign VERDICT    = (state == S_VERDICT) ? verdict_q : V_NONE;
   assign TIMER_OUT  = (state == S_ANSWER) ? tmr_count : '0;
   assign MATCH_OVER = (state == S_DONE);

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: one default-window instance and one with a
// short window and narrow round counter for expiry and saturation scenarios.
module tb_round_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0, Q_READY = 1'b0;
   logic        P1_VALID = 1'b0, P1_CORRECT = 1'b0, P2_VALID = 1'b0, P2_CORRECT = 1'b0;
   logic [1:0]  RESULT_IN = 2'b00;

   logic        new_q, match_over;
   logic [1:0]  verdict, winner;
   logic [15:0] timer_out;
   logic [7:0]  round_cnt;

   logic        t8_new_q, t8_match_over;
   logic [1:0]  t8_verdict, t8_winner;
   logic [15:0] t8_timer;
   logic [1:0]  t8_round;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   round_sequencer dut (
      .CLK(CLK), .RST(RST), .START(START), .Q_READY(Q_READY),
      .P1_VALID(P1_VALID), .P1_CORRECT(P1_CORRECT), .P2_VALID(P2_VALID), .P2_CORRECT(P2_CORRECT),
      .RESULT_IN(RESULT_IN), .NEW_Q(new_q), .VERDICT(verdict), .TIMER_OUT(timer_out),
      .ROUND_CNT(round_cnt), .MATCH_OVER(match_over), .WINNER(winner)
   );

   round_sequencer #(.TIME_LIMIT(8), .RW(2)) dut8 (
      .CLK(CLK), .RST(RST), .START(START), .Q_READY(Q_READY),
      .P1_VALID(P1_VALID), .P1_CORRECT(P1_CORRECT), .P2_VALID(P2_VALID), .P2_CORRECT(P2_CORRECT),
      .RESULT_IN(RESULT_IN), .NEW_Q(t8_new_q), .VERDICT(t8_verdict), .TIMER_OUT(t8_timer),
      .ROUND_CNT(t8_round), .MATCH_OVER(t8_match_over), .WINNER(t8_winner)
   );

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_answers;
      P1_VALID = 1'b0; P1_CORRECT = 1'b0; P2_VALID = 1'b0; P2_CORRECT = 1'b0;
   endtask

   task automatic do_reset;
      START = 1'b0; Q_READY = 1'b0; RESULT_IN = 2'b00;
      clear_answers();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   // From IDLE: REQ_Q, WAIT_Q, then into ANSWER with the timer freshly loaded.
   task automatic to_answer;
      START = 1'b1; tick(); START = 1'b0;
      tick();
      Q_READY = 1'b1; tick(); Q_READY = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1; tick();
      total++; if ({new_q, verdict, timer_out, round_cnt, match_over, winner} !== 30'd0) begin bad++; $display("FAIL reset_outputs: got %0h want 0", {new_q, verdict, timer_out, round_cnt, match_over, winner}); end
      total++; if ({t8_new_q, t8_verdict, t8_timer, t8_round, t8_match_over, t8_winner} !== 24'd0) begin bad++; $display("FAIL reset_outputs_t8: got %0h want 0", {t8_new_q, t8_verdict, t8_timer, t8_round, t8_match_over, t8_winner}); end
      RST = 1'b0; tick();
      total++; if ({new_q, verdict, timer_out, match_over} !== 20'd0) begin bad++; $display("FAIL idle_no_start: got %0h want 0", {new_q, verdict, timer_out, match_over}); end
   endtask

   task automatic test_basic_round;
      do_reset();
      START = 1'b1; tick();
      total++; if (new_q !== 1'b1) begin bad++; $display("FAIL newq_pulse: got %0b want 1", new_q); end
      START = 1'b0; tick();
      total++; if (new_q !== 1'b0) begin bad++; $display("FAIL newq_single: got %0b want 0", new_q); end
      tick(); tick();
      total++; if (timer_out !== 16'd0) begin bad++; $display("FAIL timer_wait_q: got %0d want 0", timer_out); end
      Q_READY = 1'b1; tick(); Q_READY = 1'b0;
      total++; if (timer_out !== 16'd50000) begin bad++; $display("FAIL timer_load: got %0d want 50000", timer_out); end
      repeat (9) tick();
      total++; if (timer_out !== 16'd49991) begin bad++; $display("FAIL timer_dec: got %0d want 49991", timer_out); end
      total++; if (verdict !== 2'b00) begin bad++; $display("FAIL verdict_idle_answer: got %0b want 00", verdict); end
      P1_VALID = 1'b1; P1_CORRECT = 1'b1; tick(); clear_answers();
      total++; if (verdict !== 2'b01) begin bad++; $display("FAIL verdict_p1: got %0b want 01", verdict); end
      total++; if (round_cnt !== 8'd0) begin bad++; $display("FAIL round_during_verdict: got %0d want 0", round_cnt); end
      RESULT_IN = 2'b11; tick();
      total++; if (verdict !== 2'b00) begin bad++; $display("FAIL verdict_one_cycle: got %0b want 00", verdict); end
      total++; if (round_cnt !== 8'd1) begin bad++; $display("FAIL round_inc: got %0d want 1", round_cnt); end
      total++; if (timer_out !== 16'd0) begin bad++; $display("FAIL timer_after_answer: got %0d want 0", timer_out); end
      repeat (4) tick();
      total++; if ({new_q, match_over} !== 2'b00) begin bad++; $display("FAIL gap_length: got %0b want 00", {new_q, match_over}); end
      tick();
      total++; if ({new_q, match_over} !== 2'b10) begin bad++; $display("FAIL result11_as_running: got %0b want 10", {new_q, match_over}); end
      RESULT_IN = 2'b00;
   endtask

   task automatic test_lockout;
      do_reset(); to_answer();
      P1_VALID = 1'b1; P1_CORRECT = 1'b0; tick();
      total++; if (verdict !== 2'b00) begin bad++; $display("FAIL p1_wrong_no_verdict: got %0b want 00", verdict); end
      P1_CORRECT = 1'b1; tick();
      total++; if (verdict !== 2'b00) begin bad++; $display("FAIL p1_locked_ignored: got %0b want 00", verdict); end
      clear_answers(); P2_VALID = 1'b1; P2_CORRECT = 1'b1; tick(); clear_answers();
      total++; if (verdict !== 2'b10) begin bad++; $display("FAIL p2_after_lock: got %0b want 10", verdict); end
   endtask

   task automatic test_same_cycle;
      do_reset(); to_answer();
      P1_VALID = 1'b1; P1_CORRECT = 1'b1; P2_VALID = 1'b1; P2_CORRECT = 1'b1; tick(); clear_answers();
      total++; if (verdict !== 2'b11) begin bad++; $display("FAIL both_correct: got %0b want 11", verdict); end
      do_reset(); to_answer();
      P1_VALID = 1'b1; P2_VALID = 1'b1; tick(); clear_answers();
      total++; if (verdict !== 2'b11) begin bad++; $display("FAIL both_wrong: got %0b want 11", verdict); end
      do_reset(); to_answer();
      P1_VALID = 1'b1; P1_CORRECT = 1'b1; P2_VALID = 1'b1; tick(); clear_answers();
      total++; if (verdict !== 2'b01) begin bad++; $display("FAIL mixed_p1: got %0b want 01", verdict); end
   endtask

   task automatic test_expiry;
      do_reset(); to_answer();
      total++; if (t8_timer !== 16'd8) begin bad++; $display("FAIL t8_load: got %0d want 8", t8_timer); end
      for (int i = 7; i >= 0; i--) begin
         tick();
         total++; if ({t8_timer, t8_verdict} !== {16'(i), 2'b00}) begin bad++; $display("FAIL t8_countdown: got %0d/%0b want %0d/00", t8_timer, t8_verdict, i); end
      end
      tick();
      total++; if ({t8_verdict, t8_timer} !== {2'b11, 16'd0}) begin bad++; $display("FAIL expiry_draw: got %0b/%0d want 11/0", t8_verdict, t8_timer); end
      do_reset(); to_answer();
      repeat (8) tick();
      total++; if (t8_timer !== 16'd0) begin bad++; $display("FAIL t8_at_zero: got %0d want 0", t8_timer); end
      P2_VALID = 1'b1; P2_CORRECT = 1'b1; tick(); clear_answers();
      total++; if (t8_verdict !== 2'b10) begin bad++; $display("FAIL answer_beats_expiry: got %0b want 10", t8_verdict); end
   endtask

   task automatic test_match_end;
      do_reset(); to_answer();
      P1_VALID = 1'b1; P1_CORRECT = 1'b1; tick(); clear_answers();
      tick();
      RESULT_IN = 2'b10;
      repeat (4) tick();
      total++; if (match_over !== 1'b0) begin bad++; $display("FAIL check_not_done_yet: got %0b want 0", match_over); end
      tick();
      total++; if ({match_over, winner, round_cnt} !== {1'b1, 2'b10, 8'd1}) begin bad++; $display("FAIL match_done: got %0h want %0h", {match_over, winner, round_cnt}, {1'b1, 2'b10, 8'd1}); end
      RESULT_IN = 2'b00; tick();
      total++; if ({match_over, winner, new_q} !== 4'b1100) begin bad++; $display("FAIL done_hold: got %0b want 1100", {match_over, winner, new_q}); end
      START = 1'b1; tick(); START = 1'b0;
      total++; if ({new_q, match_over, winner, round_cnt} !== {1'b1, 1'b0, 2'b00, 8'd0}) begin bad++; $display("FAIL restart: got %0h want %0h", {new_q, match_over, winner, round_cnt}, {1'b1, 1'b0, 2'b00, 8'd0}); end
   endtask

   task automatic test_async_reset;
      do_reset(); to_answer();
      repeat (3) tick();
      total++; if (timer_out !== 16'd49997) begin bad++; $display("FAIL pre_reset_timer: got %0d want 49997", timer_out); end
      #2; RST = 1'b1; #1;
      total++; if ({new_q, verdict, timer_out, round_cnt, match_over, winner} !== 30'd0) begin bad++; $display("FAIL async_reset_outputs: got %0h want 0", {new_q, verdict, timer_out, round_cnt, match_over, winner}); end
      P1_VALID = 1'b1; P1_CORRECT = 1'b1; tick(); clear_answers();
      total++; if (verdict !== 2'b00) begin bad++; $display("FAIL no_verdict_in_reset: got %0b want 00", verdict); end
      RST = 1'b0; tick();
      total++; if ({new_q, verdict, timer_out, match_over} !== 20'd0) begin bad++; $display("FAIL idle_after_reset: got %0h want 0", {new_q, verdict, timer_out, match_over}); end
      START = 1'b1; tick(); START = 1'b0;
      total++; if (new_q !== 1'b1) begin bad++; $display("FAIL start_after_reset: got %0b want 1", new_q); end
   endtask

   task automatic test_round_saturation;
      int nv;
      nv = 0;
      do_reset();
      START = 1'b1; tick(); START = 1'b0;
      Q_READY = 1'b1;
      for (int c = 0; c < 200 && nv < 5; c++) begin
         tick();
         if (t8_verdict !== 2'b00) begin
            total++; if ({t8_verdict, t8_round} !== {2'b11, 2'((nv > 3) ? 3 : nv)}) begin bad++; $display("FAIL round_progress: got %0b/%0d want 11/%0d", t8_verdict, t8_round, (nv > 3) ? 3 : nv); end
            nv++;
         end
      end
      total++; if (nv != 5) begin bad++; $display("FAIL sat_rounds_timeout: got %0d verdicts want 5", nv); end
      tick();
      Q_READY = 1'b0;
      total++; if (t8_round !== 2'd3) begin bad++; $display("FAIL round_saturate: got %0d want 3", t8_round); end
   endtask

   initial begin
      test_reset();
      test_basic_round();
      test_lockout();
      test_same_cycle();
      test_expiry();
      test_match_end();
      test_async_reset();
      test_round_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
